// File: rtl/btn_debounce_latch_if.sv
// btn_debounce_latch_if: button/display bundle; master drives btn_raw, tog_mode, clr and reads nib1, nib2, press
interface btn_debounce_latch_if;
  logic [7:0] btn_raw;
  logic       tog_mode;
  logic       clr;
  logic [3:0] nib1;
  logic [3:0] nib2;
  logic [7:0] press;
  modport master (output btn_raw, tog_mode, clr, input nib1, nib2, press);
  modport slave  (input btn_raw, tog_mode, clr, output nib1, nib2, press);
endinterface

// File: rtl/btn_debounce_latch.sv
// btn_debounce_latch: sync+debounce 8 buttons into nib1/nib2 (level or toggle view) and press pulses; ports clk190hz, rst (async active-low), bus (btn_raw, tog_mode, clr -> nib1, nib2, press)
module btn_debounce_latch #(
  parameter int DB_CNT = 4,
  parameter int CW     = 3
) (
  input logic                  clk190hz,
  input logic                  rst,
  btn_debounce_latch_if.slave  bus
);
  logic [7:0]    s1_q, s2_q, stable_q, stable_d, tog_q, tog_d, press_q, press_d;
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == CW'(DB_CNT - 1)) ? s2_q[i] : stable_q[i];
      cnt_d[i]    = (s2_q[i] == stable_q[i] || cnt_q[i] == CW'(DB_CNT - 1)) ? '0 : cnt_q[i] + CW'(1);
    end
    press_d = stable_d & ~stable_q;
    tog_d   = bus.clr ? '0 : tog_q ^ press_d;
  end
  always_ff @(posedge clk190hz or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      tog_q    <= '0;
      press_q  <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= bus.btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      tog_q    <= tog_d;
      press_q  <= press_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign bus.nib1  = bus.tog_mode ? tog_q[3:0] : stable_q[3:0];
  assign bus.nib2  = bus.tog_mode ? tog_q[7:4] : stable_q[7:4];
  assign bus.press = press_q;
endmodule

// File: tb/tb_btn_debounce_latch.sv
// tb_btn_debounce_latch: directed self-checking bench for btn_debounce_latch
module tb_btn_debounce_latch;
  logic clk190hz = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  btn_debounce_latch_if bus ();
  btn_debounce_latch dut (.clk190hz(clk190hz), .rst(rst), .bus(bus));
  always #5 clk190hz = ~clk190hz;
  task automatic tick();
    @(posedge clk190hz);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic stroke(input logic [7:0] m);
    bus.btn_raw = m;
    repeat (5) tick();
    chk("stroke_nopress_early", bus.press, 8'h00);
    tick();
    chk("stroke_press", bus.press, m);
    tick();
    chk("stroke_press_once", bus.press, 8'h00);
    bus.btn_raw = 8'h00;
    repeat (6) tick();
    chk("stroke_release_nopress", bus.press, 8'h00);
  endtask
  initial begin
    rst = 1'b1;
    bus.btn_raw = 8'h00;
    bus.tog_mode = 1'b0;
    bus.clr = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("rst_nib1", {4'h0, bus.nib1}, 8'h00);
    chk("rst_press", bus.press, 8'h00);
    rst = 1'b1;
    bus.btn_raw = 8'hFF;
    repeat (5) tick();
    chk("ff_not_yet", {bus.nib2, bus.nib1}, 8'h00);
    tick();
    chk("ff_nibs", {bus.nib2, bus.nib1}, 8'hFF);
    chk("ff_press", bus.press, 8'hFF);
    bus.btn_raw = 8'h00;
    repeat (4) tick();
    chk("partial_fall_held", {bus.nib2, bus.nib1}, 8'hFF);
    bus.btn_raw = 8'hFF;
    rst = 1'b0;
    #1;
    chk("midrst_nibs", {bus.nib2, bus.nib1}, 8'h00);
    chk("midrst_press", bus.press, 8'h00);
    repeat (2) tick();
    chk("rst_held_nibs", {bus.nib2, bus.nib1}, 8'h00);
    rst = 1'b1;
    repeat (5) tick();
    chk("post_rst_not_yet", {bus.nib2, bus.nib1}, 8'h00);
    tick();
    chk("post_rst_nibs", {bus.nib2, bus.nib1}, 8'hFF);
    chk("post_rst_press", bus.press, 8'hFF);
    tick();
    chk("post_rst_press_once", bus.press, 8'h00);
    bus.tog_mode = 1'b1;
    #1;
    chk("tog_after_press", {bus.nib2, bus.nib1}, 8'hFF);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_ff", {bus.nib2, bus.nib1}, 8'h00);
    bus.tog_mode = 1'b0;
    bus.btn_raw = 8'h00;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("fall_nopress", bus.press, 8'h00);
    end
    chk("fall_nibs", {bus.nib2, bus.nib1}, 8'h00);
    bus.btn_raw = 8'h01;
    repeat (3) tick();
    bus.btn_raw = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_nib1", {4'h0, bus.nib1}, 8'h00);
      chk("glitch_press", bus.press, 8'h00);
    end
    bus.btn_raw = 8'h01;
    repeat (5) tick();
    chk("clean_not_yet", {4'h0, bus.nib1}, 8'h00);
    chk("clean_nopress_early", bus.press, 8'h00);
    tick();
    chk("clean_nib1", {4'h0, bus.nib1}, 8'h01);
    chk("clean_press", bus.press, 8'h01);
    tick();
    chk("clean_press_once", bus.press, 8'h00);
    chk("clean_nib1_hold", {4'h0, bus.nib1}, 8'h01);
    bus.btn_raw = 8'h00;
    repeat (5) tick();
    chk("release_not_yet", {4'h0, bus.nib1}, 8'h01);
    tick();
    chk("release_nib1", {4'h0, bus.nib1}, 8'h00);
    chk("release_nopress", bus.press, 8'h00);
    bus.tog_mode = 1'b1;
    #1;
    chk("tog_start_nib2", {4'h0, bus.nib2}, 8'h00);
    chk("tog_bit0_nib1", {4'h0, bus.nib1}, 8'h01);
    stroke(8'h40);
    chk("tog1_nib2", {4'h0, bus.nib2}, 8'h04);
    stroke(8'h40);
    chk("tog2_nib2", {4'h0, bus.nib2}, 8'h00);
    stroke(8'h40);
    chk("tog3_nib2", {4'h0, bus.nib2}, 8'h04);
    bus.tog_mode = 1'b0;
    #1;
    chk("mode0_nib2", {4'h0, bus.nib2}, 8'h00);
    bus.tog_mode = 1'b1;
    #1;
    chk("mode1_nib2", {4'h0, bus.nib2}, 8'h04);
    stroke(8'h04);
    chk("tog_bit2_nib1", {4'h0, bus.nib1}, 8'h05);
    bus.btn_raw = 8'h04;
    repeat (5) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clrpri_press", bus.press, 8'h04);
    chk("clrpri_nibs", {bus.nib2, bus.nib1}, 8'h00);
    tick();
    chk("clrpri_press_once", bus.press, 8'h00);
    bus.btn_raw = 8'h00;
    repeat (6) tick();
    stroke(8'h81);
    chk("pre_idle_clr", {bus.nib2, bus.nib1}, 8'h81);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("idle_clr", {bus.nib2, bus.nib1}, 8'h00);
    bus.tog_mode = 1'b0;
    bus.btn_raw = 8'hA5;
    repeat (5) tick();
    chk("par_not_yet", {bus.nib2, bus.nib1}, 8'h00);
    tick();
    chk("par_nibs", {bus.nib2, bus.nib1}, 8'hA5);
    chk("par_press", bus.press, 8'hA5);
    tick();
    chk("par_press_once", bus.press, 8'h00);
    repeat (20) tick();
    chk("held_nopress", bus.press, 8'h00);
    chk("held_nibs", {bus.nib2, bus.nib1}, 8'hA5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce_latch.md
Name: btn_debounce_latch

Overview:
Upstream input-conditioning stage for the two-nibble seven-segment display path. It synchronises and debounces eight raw push-buttons in the clk190hz domain. It then presents them as two 4-bit values, nib1 and nib2, which feed the display controller directly. Each bit is either the debounced level or a press-toggled latch, selected per cycle by tog_mode. A one-cycle press pulse per button is also provided for downstream logic.

Parameters:
DB_CNT, 4, consecutive differing samples required to accept a level change; legal range 2..7; 4 samples ≈ 21 ms at 190 Hz.
CW, 3, width of each per-button debounce counter; must satisfy 2^CW >= DB_CNT.

Ports:
clk190hz  input  1  display/scan clock, ~190 Hz, all logic on rising edge
rst  input  1  asynchronous, active-low reset
btn_raw  input  8  raw buttons; bits [3:0] map to nib1[3:0], bits [7:4] map to nib2[3:0]
tog_mode  input  1  0 = nibbles show debounced levels; 1 = nibbles show toggle latches
clr  input  1  synchronous clear of all toggle latches
nib1  output  4  value for the first display digit
nib2  output  4  value for the second display digit
press  output  8  one-cycle pulse per button on each accepted 0→1 transition

Behaviour:
- Reset (rst=0, asynchronous) clears all of the following to 0: sync stage 1, sync stage 2, stable, cnt, tog, press. nib1 and nib2 therefore read 0 while reset is held and after it releases. Reset may assert mid-count; any partial count is discarded.
- Synchronizer: each bit passes through two flops, giving s1 ← btn_raw and then s2 ← s1.
- Debounce, per bit i, evaluated on every edge:
  - If s2[i] == stable[i], then cnt[i] ← 0.
  - Otherwise, if cnt[i] == DB_CNT-1, then stable[i] ← s2[i] and cnt[i] ← 0.
  - Otherwise, cnt[i] ← cnt[i]+1.
- Any single sample equal to stable restarts the count, so a glitch shorter than DB_CNT samples never propagates.
- Latency: btn_raw changes before edge k and then holds. stable updates at edge k+DB_CNT+1, which is edge k+5 for the default.
- press[i] is registered and asserted for exactly the one cycle following the edge where stable[i] goes 0→1. It is 0 on 1→0 transitions and 0 at all other times.
- Toggle latch tog[i] is updated on the same edge as press:
  - clr=1: tog ← 0 for all bits. clr has priority over a simultaneous press, so that press is lost from tog; press[i] itself still pulses.
  - Otherwise, a press on bit i sets tog[i] ← ~tog[i].
- Output select is combinational from registers:
  - nib1 = tog_mode ? tog[3:0] : stable[3:0]
  - nib2 = tog_mode ? tog[7:4] : stable[7:4]
- Changing tog_mode never modifies tog or stable; the output switches in the same cycle.
- A button held indefinitely produces exactly one press. A release followed by a new press needs the full DB_CNT samples in each direction.
- Buttons are fully independent. Simultaneous transitions on several bits are handled in parallel, with no priority between them.
- cnt never exceeds DB_CNT-1, so no wrap-around is possible.

Test Plan:
- Reset then idle: pulse rst low mid-run with btn_raw=8'hFF and a partial count in progress → nib1=nib2=0 and press=0 immediately. After release with btn_raw=8'hFF, nib1=nib2=4'hF at edge 5 (tog_mode=0) and press=8'hFF for one cycle.
- Glitch rejection: btn_raw[0] high for 3 edges, then low (DB_CNT=4) → stable, nib1 and press remain 0 throughout.
- Clean press latency: btn_raw=8'h01 set before edge k → nib1=4'h1 from edge k+5 and press=8'h01 only in the cycle after edge k+5. Release to 0 → nib1=0 five edges later, with no press pulse.
- Toggle mode: tog_mode=1; give btn_raw[6] three clean press/release cycles → nib2 goes 0→4'h4→0→4'h4, with one press[6] pulse per press. Switching tog_mode=0 while released shows nib2=0; switching back shows 4'h4.
- Clear priority: tog[2]=1, then clr=1 on the same edge a press on bit 2 is accepted → tog[2]=0 and press[2] still pulses once. clr on an idle cycle clears all tog bits to 0.
- Parallel buttons: btn_raw 8'h00→8'hA5 in one step → nib1=4'h5 and nib2=4'hA on the same edge, and press=8'hA5 for one cycle.
